// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared multiply/divide unit op encoding and state type
// Used by both the D-stage decoder and the E-stage MDU.
package mdu_pkg;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MFHI  = 4'd5,
      MDU_MFLO  = 4'd6,
      MDU_MTHI  = 4'd7,
      MDU_MTLO  = 4'd8
   } mdu_op_e;

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_e;

   function automatic int mdu_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage HI/LO multiply/divide unit with fixed-latency busy window
// Result is computed at acceptance and held as pending until the counter expires.
module e_mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        res,
   input  logic        E_MDU_start,
   input  logic [3:0]  E_MDU_op,
   input  logic [31:0] E_RD1,
   input  logic [31:0] E_RD2,
   output logic        E_MDU_busy,
   output logic [31:0] E_MDU_out
);

   localparam int CNT_W = $clog2(mdu_max(MULT_CYCLES, DIV_CYCLES) + 1);

   mdu_state_e        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [31:0]       hi, hi_nxt, lo, lo_nxt;
   logic [31:0]       pend_hi, pend_hi_nxt, pend_lo, pend_lo_nxt;
   logic              pend_wr, pend_wr_nxt;

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               div_zero, div_ovf;
   logic        [31:0] div_bs, div_bu;
   logic signed [31:0] quo_s, rem_s;
   logic        [31:0] quo_u, rem_u;

   // Zero divisor and the signed overflow case both divide by 1 instead:
   // the former is discarded, the latter yields exactly 0x80000000 rem 0.
   assign div_zero = (E_RD2 == 32'd0);
   assign div_ovf  = (E_RD1 == 32'h8000_0000) && (E_RD2 == 32'hFFFF_FFFF);
   assign div_bs   = (div_zero || div_ovf) ? 32'd1 : E_RD2;
   assign div_bu   = div_zero ? 32'd1 : E_RD2;

   assign prod_s = $signed({{32{E_RD1[31]}}, E_RD1}) * $signed({{32{E_RD2[31]}}, E_RD2});
   assign prod_u = {32'd0, E_RD1} * {32'd0, E_RD2};
   assign quo_s  = $signed(E_RD1) / $signed(div_bs);
   assign rem_s  = $signed(E_RD1) % $signed(div_bs);
   assign quo_u  = E_RD1 / div_bu;
   assign rem_u  = E_RD1 % div_bu;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      hi_nxt      = hi;
      lo_nxt      = lo;
      pend_hi_nxt = pend_hi;
      pend_lo_nxt = pend_lo;
      pend_wr_nxt = pend_wr;
      case (state)
         MDU_IDLE: begin
            if (E_MDU_start) begin
               case (E_MDU_op)
                  MDU_MULT: begin
                     pend_hi_nxt = prod_s[63:32];
                     pend_lo_nxt = prod_s[31:0];
                     pend_wr_nxt = 1'b1;
                     cnt_nxt     = CNT_W'(MULT_CYCLES);
                     state_nxt   = MDU_BUSY;
                  end
                  MDU_MULTU: begin
                     pend_hi_nxt = prod_u[63:32];
                     pend_lo_nxt = prod_u[31:0];
                     pend_wr_nxt = 1'b1;
                     cnt_nxt     = CNT_W'(MULT_CYCLES);
                     state_nxt   = MDU_BUSY;
                  end
                  MDU_DIV: begin
                     pend_hi_nxt = rem_s;
                     pend_lo_nxt = quo_s;
                     pend_wr_nxt = !div_zero;
                     cnt_nxt     = CNT_W'(DIV_CYCLES);
                     state_nxt   = MDU_BUSY;
                  end
                  MDU_DIVU: begin
                     pend_hi_nxt = rem_u;
                     pend_lo_nxt = quo_u;
                     pend_wr_nxt = !div_zero;
                     cnt_nxt     = CNT_W'(DIV_CYCLES);
                     state_nxt   = MDU_BUSY;
                  end
                  MDU_MTHI: hi_nxt = E_RD1;
                  MDU_MTLO: lo_nxt = E_RD1;
                  default: ;
               endcase
            end
         end
         MDU_BUSY: begin
            if (cnt <= CNT_W'(1)) begin
               state_nxt   = MDU_IDLE;
               cnt_nxt     = '0;
               pend_wr_nxt = 1'b0;
               if (pend_wr) begin
                  hi_nxt = pend_hi;
                  lo_nxt = pend_lo;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = MDU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state   <= MDU_IDLE;
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         hi      <= hi_nxt;
         lo      <= lo_nxt;
         pend_hi <= pend_hi_nxt;
         pend_lo <= pend_lo_nxt;
         pend_wr <= pend_wr_nxt;
      end
   end

   assign E_MDU_busy = (state == MDU_BUSY);

   always_comb begin
      case (E_MDU_op)
         MDU_MFHI: E_MDU_out = hi;
         MDU_MFLO: E_MDU_out = lo;
         default:  E_MDU_out = 32'd0;
      endcase
   end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: E_MDU

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port res, input, 1, asynchronous, active-low reset (res=0 resets immediately, independent of clk).
REQ-005 SHALL have port E_MDU_start, input, 1, qualifies a write-type op in the current E-stage instruction.
REQ-006 SHALL have port E_MDU_op, input, 4, operation code (shared encoding, REQ-026).
REQ-007 SHALL have port E_RD1, input, 32, rs operand from E_REG.
REQ-008 SHALL have port E_RD2, input, 32, rt operand from E_REG.
REQ-009 SHALL have port E_MDU_busy, output, 1, high while an accepted mult/div is in flight.
REQ-010 SHALL have port E_MDU_out, output, 32, HI for MFHI, LO for MFLO, else 0.

Function
REQ-011 SHALL have two states: IDLE and BUSY, with a down-counter cnt and registers HI, LO, plus latched pending result.
REQ-012 In IDLE, E_MDU_start=1 with op MULT/MULTU/DIV/DIVU SHALL latch the result and enter BUSY with cnt = MULT_CYCLES or DIV_CYCLES.
REQ-013 E_MDU_busy SHALL be high exactly N cycles after the accepting edge (N = cycle count), low otherwise.
REQ-014 At the edge ending the last BUSY cycle, HI/LO SHALL take the pending result and the state SHALL return to IDLE; new HI/LO visible the same cycle busy drops.
REQ-015 E_MDU_start in BUSY SHALL be ignored (no restart, no HI/LO write); upstream stalls this case.
REQ-016 MTHI/MTLO with E_MDU_start=1 in IDLE SHALL write E_RD1 into HI/LO at the next edge, no busy.
REQ-017 MULT/DIV SHALL treat operands as signed; MULTU/DIVU as unsigned; products full 64-bit, HI=upper, LO=lower.
REQ-018 Division SHALL give LO=quotient truncated toward zero, HI=remainder with dividend's sign.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-020 Divisor 0 SHALL still run DIV_CYCLES busy, then leave HI and LO unchanged.
REQ-021 E_MDU_out SHALL be combinational from current HI/LO, including during BUSY (pre-result values).
REQ-022 Opcodes NONE or undefined with E_MDU_start=1 SHALL be ignored.

Reset
REQ-023 res=0 SHALL immediately force IDLE, cnt=0, HI=0, LO=0, pending result=0, E_MDU_busy=0.
REQ-024 res=0 mid-operation SHALL abort; the in-flight result is never written.
REQ-025 After res returns high, the first rising edge SHALL accept a start normally.

Structure
REQ-026 Op encoding SHALL reside in shared constants header/package mdu_pkg: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; the D-stage decoder uses the same header.
REQ-027 The block SHALL have no sub-module; the arithmetic is inline behavioural operators, and the state/counter is in one sequential process.

Verification
REQ-028 MULT E_RD1=0xFFFFFFFF, E_RD2=0x00000002 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU on the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-029 DIV 0xFFFFFFF9 (-7) by 0x00000002 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 by 0 -> 10 busy cycles, HI/LO unchanged.
REQ-030 MTHI 0x12345678 then MFHI -> E_MDU_out=0x12345678 the next cycle, busy never asserts.
REQ-031 Start DIV, reissue MULT 0x3×0x4 at busy cycle 3 -> ignored; DIV result lands at cycle 10; LO != 0xC.
REQ-032 Start MULT, assert res=0 mid-cycle at busy cycle 2 -> busy, HI, LO drop to 0 without a clock edge; after release, MULT 0x3×0x4 -> LO=0x0000000C after 5 cycles.
